// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared states, win patterns and LFSR constants for the tug-of-war game
package tow_pkg;

  typedef enum logic [2:0] {
    REL   = 3'd0,
    DLY   = 3'd1,
    LIT   = 3'd2,
    SCORE = 3'd3,
    CHK   = 3'd4,
    OVER  = 3'd5
  } tow_state_t;

  // Scoreboard patterns meaning one player has pulled the rope all the way
  localparam logic [6:0] SCORE_WL = 7'b1110000;
  localparam logic [6:0] SCORE_WR = 7'b0000111;

  // x^8+x^6+x^5+x^4+1 as a right-shifting Galois feedback mask
  localparam logic [7:0] LFSR_POLY = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic is_win(input logic [6:0] s);
    return (s == SCORE_WL) || (s == SCORE_WR);
  endfunction

endpackage

// File: rtl/tow_lfsr.sv
// rtl/tow_lfsr.sv - 8-bit Galois LFSR supplying the random light delay
module tow_lfsr
  import tow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  // Shift right; when a 1 falls out the polynomial taps are folded back in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= q[0] ? ((q >> 1) ^ LFSR_POLY) : (q >> 1);
    end
  end

endmodule

// File: rtl/tow_referee.sv
// rtl/tow_referee.sv - round sequencer driving the scorer from the two player buttons
module tow_referee
  import tow_pkg::*;
#(
  parameter int LFSR_W  = 8,
  parameter int DLY_MIN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  input  logic [6:0] score,
  output logic       winrnd,
  output logic       right,
  output logic       tie,
  output logic       leds_on,
  output logic       game_over
);

  tow_state_t        state, state_nx;
  logic [8:0]        cnt, cnt_nx;
  logic              winrnd_nx, right_nx, tie_nx, leds_nx, over_nx;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_en;

  // The random source stops once the game is decided so OVER is fully static
  assign lfsr_en = (state != OVER);

  tow_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .q   (lfsr_q)
  );

  // State, counter and every output are registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REL;
      cnt       <= '0;
      winrnd    <= 1'b0;
      right     <= 1'b0;
      tie       <= 1'b0;
      leds_on   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      winrnd    <= winrnd_nx;
      right     <= right_nx;
      tie       <= tie_nx;
      leds_on   <= leds_nx;
      game_over <= over_nx;
    end
  end

  // Next state and next output values; a press always beats the delay counter
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    winrnd_nx = 1'b0;
    right_nx  = right;
    tie_nx    = tie;
    leds_nx   = leds_on;
    over_nx   = game_over;
    case (state)
      REL: begin
        if (!pbl && !pbr) begin
          cnt_nx   = 9'(DLY_MIN) + 9'(lfsr_q);
          state_nx = DLY;
        end
      end
      DLY: begin
        if (pbl || pbr) begin
          right_nx  = pbr & ~pbl;
          tie_nx    = pbl & pbr;
          winrnd_nx = 1'b1;
          state_nx  = SCORE;
        end else if (cnt != 9'd0) begin
          cnt_nx = cnt - 9'd1;
        end else begin
          leds_nx  = 1'b1;
          state_nx = LIT;
        end
      end
      LIT: begin
        if (pbl || pbr) begin
          right_nx  = pbr & ~pbl;
          tie_nx    = pbl & pbr;
          winrnd_nx = 1'b1;
          state_nx  = SCORE;
        end
      end
      SCORE: begin
        leds_nx  = 1'b0;
        state_nx = CHK;
      end
      CHK: begin
        if (is_win(score)) begin
          over_nx  = 1'b1;
          right_nx = 1'b0;
          tie_nx   = 1'b0;
          state_nx = OVER;
        end else begin
          state_nx = REL;
        end
      end
      OVER: begin
        state_nx = OVER;
      end
      default: begin
        state_nx = REL;
      end
    endcase
  end

endmodule
